sprite_loader: RTL and testbench

- Write-side initiator for the GPU sprite cluster.
- Accepts whole sprite descriptors and texture-upload commands over valid/ready handshakes.
- Serializes them into the cluster's single-word write port (waddr/wdata/wen), one word per cycle.
- Sits between the CPU/MMIO bridge and the cluster.

---
 rtl/gpu_pkg.sv | 21 ++
 rtl/sprite_loader.sv | 142 ++++++++++++++
 tb/tb_sprite_loader.sv | 177 +++++++++++++++++
 3 files changed

// File: rtl/gpu_pkg.sv
// Types and constants shared by the sprite-cluster blocks.
package gpu_pkg;

  localparam int FIELDS_PER_SPRITE = 6;

  typedef enum logic [2:0] {
    FIELD_SX  = 3'd0,
    FIELD_SY  = 3'd1,
    FIELD_STX = 3'd2,
    FIELD_STY = 3'd3,
    FIELD_STW = 3'd4,
    FIELD_STH = 3'd5
  } field_e;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    SPR  = 2'd1,
    TEX  = 2'd2
  } ld_state_e;

endpackage

// File: rtl/sprite_loader.sv
// Serializes sprite descriptors and texture uploads onto the cluster's
// single-word write port, one word per cycle.
module sprite_loader
  import gpu_pkg::*;
#(
  parameter int CLUSTER_SIZE   = 10,
  parameter int TEXTURE_WIDTH  = 64,
  parameter int TEXTURE_HEIGHT = 64,
  parameter int ADDR_WIDTH     = 16,
  parameter int INT_WIDTH      = 16,
  parameter int COLOR_WIDTH    = 12,
  localparam int SLOT_W        = $clog2(CLUSTER_SIZE)
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   spr_valid,
  output logic                   spr_ready,
  input  logic [SLOT_W-1:0]      spr_slot,
  input  logic [INT_WIDTH-1:0]   spr_x,
  input  logic [INT_WIDTH-1:0]   spr_y,
  input  logic [INT_WIDTH-1:0]   spr_tx,
  input  logic [INT_WIDTH-1:0]   spr_ty,
  input  logic [INT_WIDTH-1:0]   spr_tw,
  input  logic [INT_WIDTH-1:0]   spr_th,
  input  logic                   tex_valid,
  output logic                   tex_ready,
  input  logic [ADDR_WIDTH-1:0]  tex_start,
  input  logic [ADDR_WIDTH-1:0]  tex_len,
  input  logic                   px_valid,
  output logic                   px_ready,
  input  logic [COLOR_WIDTH-1:0] px_data,
  output logic [ADDR_WIDTH-1:0]  waddr,
  output logic [INT_WIDTH-1:0]   wdata,
  output logic                   wen,
  output logic                   busy,
  output logic                   err
);

  localparam logic [ADDR_WIDTH:0]   TEX_SIZE = (ADDR_WIDTH+1)'(TEXTURE_WIDTH*TEXTURE_HEIGHT);
  localparam logic [ADDR_WIDTH-1:0] TEX_BASE = ADDR_WIDTH'(CLUSTER_SIZE*FIELDS_PER_SPRITE);

  ld_state_e state, state_n;
  logic [FIELDS_PER_SPRITE-1:0][INT_WIDTH-1:0] fld;
  logic [2:0]            f, f_nx;
  logic [ADDR_WIDTH-1:0] t_start, t_len, i;
  logic                  slot_ok, tex_over, px_in, last_px, last_fld;
  logic [ADDR_WIDTH:0]   px_idx;

  // Clip checks run one bit wider so address wrap can never hide an overrun.
  assign slot_ok  = 32'(spr_slot) < 32'(CLUSTER_SIZE);
  assign tex_over = ({1'b0, tex_start} + {1'b0, tex_len}) > TEX_SIZE;
  assign px_idx   = {1'b0, t_start} + {1'b0, i};
  assign px_in    = px_idx < TEX_SIZE;
  assign last_px  = (i == t_len - 1'b1);
  assign last_fld = (f == 3'(FIELD_STH));
  assign f_nx     = f + 3'd1;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state <= IDLE;
    else      state <= state_n;
  end

  always_comb begin
    state_n = state;
    case (state)
      IDLE: begin
        if (spr_valid) begin
          if (slot_ok) state_n = SPR;
        end else if (tex_valid && tex_len != '0) begin
          state_n = TEX;
        end
      end
      SPR:     if (last_fld) state_n = IDLE;
      TEX:     if (px_valid && last_px) state_n = IDLE;
      default: state_n = IDLE;
    endcase
  end

  always_comb begin
    spr_ready = (state == IDLE);
    tex_ready = (state == IDLE) && !spr_valid;
    px_ready  = (state == TEX);
    busy      = (state != IDLE);
  end

  // The first sprite word is launched on the accept edge so that words land
  // in the six cycles right after the handshake; SPR then tracks field f on the bus.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      fld     <= '0;
      f       <= '0;
      t_start <= '0;
      t_len   <= '0;
      i       <= '0;
      waddr   <= '0;
      wdata   <= '0;
      wen     <= 1'b0;
      err     <= 1'b0;
    end else begin
      wen <= 1'b0;
      err <= 1'b0;
      case (state)
        IDLE: begin
          if (spr_valid) begin
            if (!slot_ok) begin
              err <= 1'b1;
            end else begin
              fld   <= {spr_th, spr_tw, spr_ty, spr_tx, spr_y, spr_x};
              f     <= '0;
              waddr <= ADDR_WIDTH'(spr_slot) * ADDR_WIDTH'(FIELDS_PER_SPRITE);
              wdata <= spr_x;
              wen   <= 1'b1;
            end
          end else if (tex_valid && tex_len != '0) begin
            t_start <= tex_start;
            t_len   <= tex_len;
            i       <= '0;
            err     <= tex_over;
          end
        end
        SPR: begin
          if (!last_fld) begin
            f     <= f_nx;
            waddr <= waddr + 1'b1;
            wdata <= fld[f_nx];
            wen   <= 1'b1;
          end
        end
        TEX: begin
          if (px_valid) begin
            i     <= i + 1'b1;
            waddr <= TEX_BASE + t_start + i;
            wdata <= INT_WIDTH'(px_data);
            wen   <= px_in;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_sprite_loader.sv
// Directed bench for sprite_loader with hand-computed expected values.
module tb_sprite_loader;

  logic        clk = 1'b0;
  logic        rst;
  logic        spr_valid, spr_ready;
  logic [3:0]  spr_slot;
  logic [15:0] spr_x, spr_y, spr_tx, spr_ty, spr_tw, spr_th;
  logic        tex_valid, tex_ready;
  logic [15:0] tex_start, tex_len;
  logic        px_valid, px_ready;
  logic [11:0] px_data;
  logic [15:0] waddr, wdata;
  logic        wen, busy, err;

  int vectors = 0;
  int miscompares = 0;

  sprite_loader dut (
    .clk(clk), .rst(rst),
    .spr_valid(spr_valid), .spr_ready(spr_ready), .spr_slot(spr_slot),
    .spr_x(spr_x), .spr_y(spr_y), .spr_tx(spr_tx), .spr_ty(spr_ty),
    .spr_tw(spr_tw), .spr_th(spr_th),
    .tex_valid(tex_valid), .tex_ready(tex_ready),
    .tex_start(tex_start), .tex_len(tex_len),
    .px_valid(px_valid), .px_ready(px_ready), .px_data(px_data),
    .waddr(waddr), .wdata(wdata), .wen(wen), .busy(busy), .err(err)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk_wr(input string tag, input logic [15:0] a, input logic [15:0] d);
    check({tag, ".wen"}, 32'(wen), 32'd1);
    check({tag, ".waddr"}, 32'(waddr), 32'(a));
    check({tag, ".wdata"}, 32'(wdata), 32'(d));
  endtask

  int unsigned exp_d [6] = '{10, 20, 0, 16, 16, 16};

  initial begin
    rst = 1'b0; spr_valid = 1'b1; spr_slot = 4'd3;
    spr_x = 16'd10; spr_y = 16'd20; spr_tx = 16'd0;
    spr_ty = 16'd16; spr_tw = 16'd16; spr_th = 16'd16;
    tex_valid = 1'b0; tex_start = '0; tex_len = '0;
    px_valid = 1'b0; px_data = '0;

    // reset held with a pending sprite
    for (int k = 0; k < 3; k++) begin
      tick();
      check("rst.wen", 32'(wen), 32'd0);
      check("rst.busy", 32'(busy), 32'd0);
      check("rst.err", 32'(err), 32'd0);
    end
    rst = 1'b1;
    #1 check("spr.ready", 32'(spr_ready), 32'd1);

    // sprite slot 3 -> addresses 18..23
    tick();
    spr_valid = 1'b0;
    for (int k = 0; k < 6; k++) begin
      chk_wr($sformatf("spr.f%0d", k), 16'(18 + k), 16'(exp_d[k]));
      check("spr.busy", 32'(busy), 32'd1);
      check("spr.rdy_low", 32'(spr_ready), 32'd0);
      tick();
    end
    check("spr.done_wen", 32'(wen), 32'd0);
    check("spr.ready_n7", 32'(spr_ready), 32'd1);
    check("spr.idle", 32'(busy), 32'd0);

    // out-of-range slot
    spr_valid = 1'b1; spr_slot = 4'd12;
    tick();
    spr_valid = 1'b0;
    check("bad.err", 32'(err), 32'd1);
    check("bad.wen", 32'(wen), 32'd0);
    check("bad.busy", 32'(busy), 32'd0);
    tick();
    check("bad.err_pulse", 32'(err), 32'd0);
    check("bad.wen2", 32'(wen), 32'd0);

    // sprite beats texture; texture start=100 len=4
    spr_valid = 1'b1; spr_slot = 4'd0;
    spr_x = 16'd1; spr_y = 16'd2; spr_tx = 16'd3; spr_ty = 16'd4; spr_tw = 16'd5; spr_th = 16'd6;
    tex_valid = 1'b1; tex_start = 16'd100; tex_len = 16'd4;
    #1;
    check("pri.tex_ready", 32'(tex_ready), 32'd0);
    check("pri.spr_ready", 32'(spr_ready), 32'd1);
    tick();
    spr_valid = 1'b0;
    for (int k = 0; k < 6; k++) begin
      chk_wr($sformatf("pri.f%0d", k), 16'(k), 16'(k + 1));
      check("pri.tex_blocked", 32'(tex_ready), 32'd0);
      tick();
    end
    check("pri.tex_ready_idle", 32'(tex_ready), 32'd1);
    tick();
    tex_valid = 1'b0;
    check("tex.busy", 32'(busy), 32'd1);
    check("tex.px_ready", 32'(px_ready), 32'd1);
    check("tex.err", 32'(err), 32'd0);
    check("tex.wen0", 32'(wen), 32'd0);

    px_valid = 1'b1; px_data = 12'hABC;
    tick(); chk_wr("tex.p0", 16'd160, 16'h0ABC);
    px_data = 12'h123;
    tick(); chk_wr("tex.p1", 16'd161, 16'h0123);
    px_valid = 1'b0;
    tick();
    check("tex.gap_wen", 32'(wen), 32'd0);
    check("tex.gap_ready", 32'(px_ready), 32'd1);
    px_valid = 1'b1; px_data = 12'hFFF;
    tick(); chk_wr("tex.p2", 16'd162, 16'h0FFF);
    px_data = 12'h000;
    tick(); chk_wr("tex.p3", 16'd163, 16'h0000);
    px_valid = 1'b0;
    check("tex.px_ready_drop", 32'(px_ready), 32'd0);
    check("tex.idle", 32'(busy), 32'd0);

    // clipped upload: start=4094 len=4
    tex_valid = 1'b1; tex_start = 16'd4094; tex_len = 16'd4;
    tick();
    tex_valid = 1'b0;
    check("clip.err", 32'(err), 32'd1);
    check("clip.px_ready", 32'(px_ready), 32'd1);
    px_valid = 1'b1; px_data = 12'h111;
    tick();
    chk_wr("clip.p0", 16'd4154, 16'h0111);
    check("clip.err_pulse", 32'(err), 32'd0);
    tick(); chk_wr("clip.p1", 16'd4155, 16'h0111);
    tick(); check("clip.p2_wen", 32'(wen), 32'd0);
    tick(); check("clip.p3_wen", 32'(wen), 32'd0);
    px_valid = 1'b0;
    check("clip.consumed", 32'(px_ready), 32'd0);
    check("clip.idle", 32'(busy), 32'd0);

    // zero-length upload
    tex_valid = 1'b1; tex_start = 16'd5; tex_len = 16'd0;
    tick();
    tex_valid = 1'b0;
    check("zero.err", 32'(err), 32'd0);
    check("zero.wen", 32'(wen), 32'd0);
    check("zero.busy", 32'(busy), 32'd0);

    // reset mid-sprite aborts
    spr_valid = 1'b1; spr_slot = 4'd1;
    tick();
    spr_valid = 1'b0;
    chk_wr("abort.f0", 16'd6, 16'd1);
    tick();
    rst = 1'b0;
    #1;
    check("abort.wen", 32'(wen), 32'd0);
    check("abort.busy", 32'(busy), 32'd0);
    tick();
    rst = 1'b1;
    tick();
    check("abort.no_wr", 32'(wen), 32'd0);
    check("abort.idle", 32'(busy), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
